// File: rtl/fb_pkg.sv
// Shared constants, FSM encoding and write-buffer payload for frame_buf_arbiter.
package fb_pkg;

    localparam int unsigned H_ACTIVE    = 640;
    localparam int unsigned V_ACTIVE    = 480;
    localparam int unsigned PIX_COUNT   = H_ACTIVE * V_ACTIVE;
    localparam int unsigned ADDR_W      = 19;
    localparam int unsigned RGB_W       = 12;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned MEM_ADDR_W  = ADDR_W + 1;
    localparam int unsigned FRAME_CNT_W = 8;

    typedef enum logic {
        RUN       = 1'b0,
        SWAP_PEND = 1'b1
    } fb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [RGB_W-1:0]  data;
    } wr_entry_t;

    // True when a pixel address lies inside the visible 640x480 frame.
    function automatic logic in_frame(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(PIX_COUNT);
    endfunction

endpackage

// File: rtl/frame_buf_arbiter_if.sv
// Bus bundle around frame_buf_arbiter: vga_driver read port, camera write
// port, frame/vsync control, single-port RAM port and bank status.
// slave  : the arbiter side.
// master : the environment (camera, vga_driver, RAM).
interface frame_buf_arbiter_if;
    import fb_pkg::*;

    logic                   rd_req;
    logic [ADDR_W-1:0]      rd_addr;
    logic [RGB_W-1:0]       rd_data;
    logic                   vga_vs;
    logic                   wr_valid;
    logic [ADDR_W-1:0]      wr_addr;
    logic [RGB_W-1:0]       wr_data;
    logic                   wr_ready;
    logic                   frame_done;
    logic                   mem_en;
    logic                   mem_we;
    logic [MEM_ADDR_W-1:0]  mem_addr;
    logic [RGB_W-1:0]       mem_wdata;
    logic [RGB_W-1:0]       mem_rdata;
    logic                   wr_bank;
    logic                   swap_pulse;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    modport slave (
        input  rd_req, rd_addr, vga_vs, wr_valid, wr_addr, wr_data,
               frame_done, mem_rdata,
        output rd_data, wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
               wr_bank, swap_pulse, frame_cnt
    );

    modport master (
        output rd_req, rd_addr, vga_vs, wr_valid, wr_addr, wr_data,
               frame_done, mem_rdata,
        input  rd_data, wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
               wr_bank, swap_pulse, frame_cnt
    );

endinterface

// File: rtl/fb_wr_fifo.sv
// Camera write buffer: synchronous FIFO of {addr, data} entries.
// Ports: clk, rst_n (async active-low), push/push_data, pop,
//        full_c/empty_c/head_c (combinational views of registered state).
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wr_entry_t push_data,
    input  logic      pop,
    output logic      full_c,
    output logic      empty_c,
    output wr_entry_t head_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0] wr_ptr_q;
    logic [PTR_W:0] rd_ptr_q;
    wr_entry_t      mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_c  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;

    // Pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    // Entry storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/frame_buf_arbiter.sv
// Ping-pong frame-buffer arbiter: shares one single-port RAM between the
// camera writer (buffered through fb_wr_fifo) and the vga_driver reader.
// Reads always win the RAM port; buffered writes drain in read-free cycles.
// Banks swap on a vga_vs falling edge once a camera frame is complete and
// the write buffer has drained.
// Ports: vga_clk, sys_rst_n (async active-low), bus (frame_buf_arbiter_if.slave).
module frame_buf_arbiter
    import fb_pkg::*;
(
    input  logic                vga_clk,
    input  logic                sys_rst_n,
    frame_buf_arbiter_if.slave  bus
);

    fb_state_e              state_q;
    fb_state_e              state_d;
    logic                   swap_d;
    logic                   vs_q;
    logic                   vs_fall_c;
    logic                   wr_bank_q;
    logic                   swap_pulse_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   rd_pend_q;
    logic                   rd_ok_q;
    logic [RGB_W-1:0]       rd_hold_q;
    logic [RGB_W-1:0]       rd_data_c;
    logic                   wr_ready_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   fifo_full_c;
    logic                   fifo_empty_c;
    wr_entry_t              push_entry_c;
    wr_entry_t              head_c;

    assign wr_ready_c   = !fifo_full_c && (state_q == RUN);
    // Out-of-frame writes are acknowledged but never reach the RAM.
    assign push_c       = bus.wr_valid && wr_ready_c && in_frame(bus.wr_addr);
    assign pop_c        = !bus.rd_req && !fifo_empty_c;
    assign push_entry_c = '{addr: bus.wr_addr, data: bus.wr_data};
    assign vs_fall_c    = vs_q && !bus.vga_vs;

    fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk       (vga_clk),
        .rst_n     (sys_rst_n),
        .push      (push_c),
        .push_data (push_entry_c),
        .pop       (pop_c),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c),
        .head_c    (head_c)
    );

    // RAM port mux: read has priority, else drain one buffered write.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (bus.rd_req) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = {~wr_bank_q, bus.rd_addr};
        end else if (!fifo_empty_c) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = {wr_bank_q, head_c.addr};
            bus.mem_wdata = head_c.data;
        end
    end

    // Next-state logic for the bank-swap FSM.
    always_comb begin
        state_d = state_q;
        swap_d  = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.frame_done) state_d = SWAP_PEND;
            end
            SWAP_PEND: begin
                if (vs_fall_c && fifo_empty_c) begin
                    state_d = RUN;
                    swap_d  = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State, bank/swap status and read-return bookkeeping.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= RUN;
            vs_q         <= 1'b1;
            wr_bank_q    <= 1'b0;
            swap_pulse_q <= 1'b0;
            frame_cnt_q  <= '0;
            rd_pend_q    <= 1'b0;
            rd_ok_q      <= 1'b0;
            rd_hold_q    <= '0;
        end else begin
            state_q      <= state_d;
            vs_q         <= bus.vga_vs;
            wr_bank_q    <= wr_bank_q ^ swap_d;
            swap_pulse_q <= swap_d;
            frame_cnt_q  <= frame_cnt_q + FRAME_CNT_W'(swap_d);
            rd_pend_q    <= bus.rd_req;
            rd_ok_q      <= in_frame(bus.rd_addr);
            rd_hold_q    <= rd_data_c;
        end
    end

    // The RAM's own output register provides the read-data flop; this mux
    // only zeroes out-of-frame reads and holds the last pixel between reads.
    assign rd_data_c = rd_pend_q ? (rd_ok_q ? bus.mem_rdata : '0) : rd_hold_q;

    assign bus.rd_data    = rd_data_c;
    assign bus.wr_ready   = wr_ready_c;
    assign bus.wr_bank    = wr_bank_q;
    assign bus.swap_pulse = swap_pulse_q;
    assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Directed bench for frame_buf_arbiter with a behavioural single-port RAM.
module tb_frame_buf_arbiter;
    import fb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   wr_events = 0;
    int   mark;

    always #5 clk = ~clk;

    frame_buf_arbiter_if bus();

    frame_buf_arbiter dut (
        .vga_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    // Synchronous-read RAM, both banks; bank1 addr 5 preloaded during reset.
    bit [RGB_W-1:0] ram [0:(1<<MEM_ADDR_W)-1];
    always @(posedge clk) begin
        if (!rst_n) begin
            ram[20'h80005] <= 12'hABC;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    always @(posedge clk) begin
        if (rst_n && bus.mem_en && bus.mem_we) wr_events <= wr_events + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rd_req     = 1'b0;
        bus.rd_addr    = '0;
        bus.vga_vs     = 1'b1;
        bus.wr_valid   = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.frame_done = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #2;
        check("rst_wr_bank",   32'(bus.wr_bank), 0);
        check("rst_rd_data",   32'(bus.rd_data), 0);
        check("rst_mem_en",    32'(bus.mem_en), 0);
        check("rst_mem_we",    32'(bus.mem_we), 0);
        check("rst_mem_addr",  32'(bus.mem_addr), 0);
        check("rst_swap",      32'(bus.swap_pulse), 0);
        check("rst_frame_cnt", 32'(bus.frame_cnt), 0);
        check("rst_wr_ready",  32'(bus.wr_ready), 1);
        rst_n = 1'b1;

        // 1: read from read bank (bank1)
        tick();
        bus.rd_req = 1'b1; bus.rd_addr = 19'd5;
        #1;
        check("t1_mem_addr", 32'(bus.mem_addr), 32'h80005);
        check("t1_mem_we",   32'(bus.mem_we), 0);
        check("t1_mem_en",   32'(bus.mem_en), 1);
        tick();
        bus.rd_req = 1'b0;
        #1;
        check("t1_rd_data", 32'(bus.rd_data), 32'hABC);
        tick();
        check("t1_rd_hold", 32'(bus.rd_data), 32'hABC);

        // 2: write held off by 3 read cycles
        bus.rd_req = 1'b1; bus.rd_addr = 19'd0;
        bus.wr_valid = 1'b1; bus.wr_addr = 19'd10; bus.wr_data = 12'h123;
        #1;
        check("t2_wr_ready", 32'(bus.wr_ready), 1);
        tick();
        bus.wr_valid = 1'b0;
        #1;
        check("t2_no_we_1", 32'(bus.mem_we), 0);
        tick();
        check("t2_no_we_2", 32'(bus.mem_we), 0);
        tick();
        bus.rd_req = 1'b0;
        #1;
        check("t2_we",    32'(bus.mem_we), 1);
        check("t2_addr",  32'(bus.mem_addr), 32'h0000A);
        check("t2_wdata", 32'(bus.mem_wdata), 32'h123);

        // 3: fill the FIFO under reads, then drain in order
        tick();
        bus.rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = 19'(20 + i); bus.wr_data = 12'(12'h200 + i);
            #1;
            check("t3_ready_fill", 32'(bus.wr_ready), 1);
            tick();
        end
        bus.wr_valid = 1'b0;
        #1;
        check("t3_full", 32'(bus.wr_ready), 0);
        tick();
        bus.rd_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t3_drain_we",    32'(bus.mem_we), 1);
            check("t3_drain_addr",  32'(bus.mem_addr), 32'(20 + k));
            check("t3_drain_wdata", 32'(bus.mem_wdata), 32'(32'h200 + k));
            tick();
        end
        check("t3_ready_after", 32'(bus.wr_ready), 1);
        check("t3_idle",        32'(bus.mem_en), 0);

        // 4: frame_done, swap at vs falling edge with empty FIFO
        bus.frame_done = 1'b1;
        tick();
        bus.frame_done = 1'b0;
        #1;
        check("t4_pend_ready", 32'(bus.wr_ready), 0);
        tick();
        bus.vga_vs = 1'b0;
        bus.rd_req = 1'b1; bus.rd_addr = 19'd7;
        #1;
        check("t4_swapcyc_addr", 32'(bus.mem_addr), 32'h80007);
        check("t4_swapcyc_bank", 32'(bus.wr_bank), 0);
        tick();
        bus.rd_addr = 19'd0;
        #1;
        check("t4_swap_pulse", 32'(bus.swap_pulse), 1);
        check("t4_wr_bank",    32'(bus.wr_bank), 1);
        check("t4_frame_cnt",  32'(bus.frame_cnt), 1);
        check("t4_new_addr",   32'(bus.mem_addr), 32'h00000);
        check("t4_ready",      32'(bus.wr_ready), 1);
        tick();
        bus.rd_req = 1'b0; bus.vga_vs = 1'b1;
        #1;
        check("t4_pulse_1cyc", 32'(bus.swap_pulse), 0);

        // 5: swap deferred while writes are buffered at the vs edge
        tick();
        bus.rd_req = 1'b1;
        bus.wr_valid = 1'b1; bus.wr_addr = 19'd30; bus.wr_data = 12'h330;
        #1;
        check("t5_ready", 32'(bus.wr_ready), 1);
        tick();
        bus.wr_addr = 19'd31; bus.wr_data = 12'h331; bus.frame_done = 1'b1;
        tick();
        bus.wr_valid = 1'b0; bus.frame_done = 1'b0; bus.vga_vs = 1'b0;
        #1;
        check("t5_pend_ready", 32'(bus.wr_ready), 0);
        tick();
        check("t5_no_swap",    32'(bus.swap_pulse), 0);
        check("t5_bank_kept",  32'(bus.wr_bank), 1);
        tick();
        bus.rd_req = 1'b0; bus.vga_vs = 1'b1;
        #1;
        check("t5_pop0_we",    32'(bus.mem_we), 1);
        check("t5_pop0_addr",  32'(bus.mem_addr), 32'h8001E);
        check("t5_pop0_wdata", 32'(bus.mem_wdata), 32'h330);
        check("t5_pop0_ready", 32'(bus.wr_ready), 0);
        tick();
        check("t5_pop1_addr",  32'(bus.mem_addr), 32'h8001F);
        check("t5_pop1_wdata", 32'(bus.mem_wdata), 32'h331);
        tick();
        check("t5_empty_en",   32'(bus.mem_en), 0);
        check("t5_still_pend", 32'(bus.wr_ready), 0);
        check("t5_bank_still", 32'(bus.wr_bank), 1);
        tick();
        bus.vga_vs = 1'b0;
        tick();
        bus.vga_vs = 1'b1;
        #1;
        check("t5_swap_pulse", 32'(bus.swap_pulse), 1);
        check("t5_wr_bank",    32'(bus.wr_bank), 0);
        check("t5_frame_cnt",  32'(bus.frame_cnt), 2);
        check("t5_ready_run",  32'(bus.wr_ready), 1);

        // 6: out-of-frame write/read, plus last in-frame address
        tick();
        mark = wr_events;
        bus.rd_req = 1'b1; bus.rd_addr = 19'd5;
        bus.wr_valid = 1'b1; bus.wr_addr = 19'd307200; bus.wr_data = 12'hFFF;
        #1;
        check("t6_oob_ready", 32'(bus.wr_ready), 1);
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_addr = 19'd307200;
        #1;
        check("t6_inrange_rd", 32'(bus.rd_data), 32'hABC);
        check("t6_oob_mem_en", 32'(bus.mem_en), 1);
        check("t6_oob_mem_we", 32'(bus.mem_we), 0);
        tick();
        bus.rd_req = 1'b0;
        #1;
        check("t6_oob_rd", 32'(bus.rd_data), 0);
        repeat (3) tick();
        check("t6_oob_hold", 32'(bus.rd_data), 0);
        check("t6_no_we",    32'(bus.mem_en), 0);
        check("t6_no_write", 32'(wr_events), 32'(mark));
        bus.wr_valid = 1'b1; bus.wr_addr = 19'd307199; bus.wr_data = 12'h5A5;
        tick();
        bus.wr_valid = 1'b0;
        #1;
        check("t6_last_we",   32'(bus.mem_we), 1);
        check("t6_last_addr", 32'(bus.mem_addr), 32'h4AFFF);
        tick();
        check("t6_last_cnt", 32'(wr_events), 32'(mark + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
